sa_input_skew_mover: RTL and testbench

//  Downstream stage of the global buffer. Takes PE_SIZE-byte activation vectors from GLB memory 0.

---
 rtl/tpu_glb_pkg.sv | 34 +++
 rtl/sa_row_fifo.sv | 54 +++++
 rtl/sa_input_skew_mover.sv | 97 +++++++++
 tb/tb_sa_input_skew_mover.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_glb_pkg.sv
// Shared GLB/array-edge types: lane geometry, FIFO sizing,
// skew-mover FSM encoding and lane slicing.
package tpu_glb_pkg;

  localparam int PE_SIZE    = 14;
  localparam int DATA_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int VEC_W      = PE_SIZE * DATA_WIDTH;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  typedef struct packed {
    logic             last;
    logic [VEC_W-1:0] data;
  } row_t;

  typedef struct packed {
    logic                  v;
    logic [DATA_WIDTH-1:0] d;
  } cell_t;

  function automatic logic [DATA_WIDTH-1:0] lane_of(
    input logic [VEC_W-1:0] v,
    input int unsigned      i
  );
    return v[i*DATA_WIDTH +: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/sa_row_fifo.sv
// Row FIFO between the GLB read port and the skew chains.
// Count-based full/empty; pointers wrap on the power-of-2 depth.
module sa_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign count   = cnt;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sa_input_skew_mover.sv
// Row FIFO + diagonal skew onto the systolic-array west edge;
// flushes the skew at tile end and pulses done_o.
module sa_input_skew_mover
  import tpu_glb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VEC_W-1:0]   in_data_i,
  input  logic               in_valid_i,
  input  logic               in_last_i,
  output logic               in_ready_o,
  input  logic               sa_en_i,
  output logic [VEC_W-1:0]   out_data_o,
  output logic [PE_SIZE-1:0] out_valid_o,
  output logic               busy_o,
  output logic               done_o
);

  row_t               wr_row;
  row_t               head;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic               pop;
  logic               pop_last;
  logic [PE_SIZE-1:0] last_q;
  state_e             state_q;
  state_e             state_d;

  assign wr_row = '{last: in_last_i, data: in_data_i};

  sa_row_fifo #(
    .WIDTH($bits(row_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid_i),
    .wr_data (wr_row),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // IDLE may pop on the same edge it leaves, keeping latency at one edge
  assign pop        = sa_en_i && !empty && (state_q != DRAIN);
  assign pop_last   = pop && head.last;
  assign in_ready_o = !full;
  assign busy_o     = state_q != IDLE;
  assign done_o     = last_q[PE_SIZE-1] && sa_en_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (count != '0) state_d = pop_last ? DRAIN : STREAM;
      end
      STREAM: begin
        if (pop_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (done_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_q <= '0;
    else if (sa_en_i) last_q <= {last_q[PE_SIZE-2:0], pop_last};
  end

  for (genvar g = 0; g < PE_SIZE; g++) begin : g_lane
    cell_t c_q [g+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= g; k++) c_q[k] <= '0;
      end else if (sa_en_i) begin
        c_q[0].v <= pop;
        c_q[0].d <= pop ? lane_of(head.data, g) : '0;
        for (int k = 1; k <= g; k++) c_q[k] <= c_q[k-1];
      end
    end

    assign out_data_o[g*DATA_WIDTH +: DATA_WIDTH] = c_q[g].d;
    assign out_valid_o[g]                         = c_q[g].v;
  end

endmodule

// File: tb/tb_sa_input_skew_mover.sv
// Directed bench for sa_input_skew_mover: per-cycle output log
// compared against hand-built diagonal expectations.
module tb_sa_input_skew_mover;
  import tpu_glb_pkg::*;

  localparam int W  = VEC_W;
  localparam int DW = DATA_WIDTH;
  localparam int N  = 2048;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [W-1:0]       in_data_i;
  logic               in_valid_i;
  logic               in_last_i;
  logic               in_ready_o;
  logic               sa_en_i;
  logic [W-1:0]       out_data_o;
  logic [PE_SIZE-1:0] out_valid_o;
  logic               busy_o;
  logic               done_o;

  sa_input_skew_mover dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_last_i   (in_last_i),
    .in_ready_o  (in_ready_o),
    .sa_en_i     (sa_en_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0]       m_d [N];
  logic [PE_SIZE-1:0] m_v [N];
  logic               m_dn [N];
  logic               m_bz [N];

  always @(negedge clk) begin
    if (cyc < N) begin
      m_d[cyc]  <= out_data_o;
      m_v[cyc]  <= out_valid_o;
      m_dn[cyc] <= done_o;
      m_bz[cyc] <= busy_o;
    end
  end

  logic [W-1:0]       nom_d [N];
  logic [PE_SIZE-1:0] nom_v [N];
  logic               nom_dn [N];
  logic               nom_bz [N];

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           done_off;
    int           busy_len;
  } vec_rec_t;

  vec_rec_t tbl [4];

  function automatic logic [W-1:0] mk(input int k);
    logic [W-1:0] r;
    for (int i = 0; i < PE_SIZE; i++) r[i*DW +: DW] = 8'(k*14 + i + 1);
    return r;
  endfunction

  function automatic int map_c(input int c, input int fz0, input int fzn);
    if (fzn == 0 || c <= fz0) return c;
    if (c <= fz0 + fzn) return fz0;
    return c - fzn;
  endfunction

  task automatic clear_nom();
    for (int c = 0; c < N; c++) begin
      nom_d[c]  = '0;
      nom_v[c]  = '0;
      nom_dn[c] = 1'b0;
      nom_bz[c] = 1'b0;
    end
  endtask

  task automatic add_vec(input int c0, input logic [W-1:0] d);
    for (int i = 0; i < PE_SIZE; i++) begin
      nom_v[c0+i][i]          = 1'b1;
      nom_d[c0+i][i*DW +: DW] = d[i*DW +: DW];
    end
  endtask

  task automatic set_busy(input int a, input int b);
    for (int c = a; c <= b; c++) nom_bz[c] = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic l,
                      input logic en, output logic acc);
    in_valid_i = v;
    in_data_i  = d;
    in_last_i  = l;
    sa_en_i    = en;
    acc        = v && in_ready_o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic en);
    logic a;
    repeat (n) step(1'b0, '0, 1'b0, en, a);
  endtask

  task automatic check_window(input string nm, input int w0, input int w1,
                              input int fz0, input int fzn, input bit chk_bz);
    int bad;
    int m;
    for (int i = 0; i < PE_SIZE; i++) begin
      bad = -1;
      for (int c = w0; c <= w1; c++) begin
        m = map_c(c, fz0, fzn);
        if (bad < 0 && (m_v[c][i] !== nom_v[m][i] ||
            m_d[c][i*DW +: DW] !== nom_d[m][i*DW +: DW])) bad = c;
      end
      n_cmp++;
      if (bad >= 0) begin
        m = map_c(bad, fz0, fzn);
        n_bad++;
        $display("FAIL %s lane %0d cyc %0d: got v=%b d=%h want v=%b d=%h",
                 nm, i, bad - w0, m_v[bad][i], m_d[bad][i*DW +: DW],
                 nom_v[m][i], nom_d[m][i*DW +: DW]);
      end
    end
    bad = -1;
    for (int c = w0; c <= w1; c++)
      if (bad < 0 && m_dn[c] !== nom_dn[map_c(c, fz0, fzn)]) bad = c;
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s done cyc %0d: got %b want %b", nm, bad - w0,
               m_dn[bad], nom_dn[map_c(bad, fz0, fzn)]);
    end
    if (chk_bz) begin
      bad = -1;
      for (int c = w0; c <= w1; c++)
        if (bad < 0 && m_bz[c] !== nom_bz[map_c(c, fz0, fzn)]) bad = c;
      n_cmp++;
      if (bad >= 0) begin
        n_bad++;
        $display("FAIL %s busy cyc %0d: got %b want %b", nm, bad - w0,
                 m_bz[bad], nom_bz[map_c(bad, fz0, fzn)]);
      end
    end
  endtask

  initial begin
    logic acc;
    int   e;
    int   c;

    for (int i = 0; i < PE_SIZE; i++) begin
      tbl[0].data[i*DW +: DW] = 8'(i + 1);
      tbl[1].data[i*DW +: DW] = 8'hFF;
      tbl[2].data[i*DW +: DW] = (i % 2 == 0) ? 8'hA5 : 8'h5A;
      tbl[3].data[i*DW +: DW] = 8'h80 >> (i % 8);
    end
    for (int t = 0; t < 4; t++) begin
      tbl[t].last     = 1'b1;
      tbl[t].done_off = 14;
      tbl[t].busy_len = 14;
    end

    rst_n      = 1'b0;
    in_data_i  = '0;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    sa_en_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", W'(out_valid_o), '0);
    chk("rst_data", out_data_o, '0);
    chk("rst_done", W'(done_o), '0);
    chk("rst_busy", W'(busy_o), '0);
    chk("rst_ready", W'(in_ready_o), W'(1));
    rst_n = 1'b1;
    idle(2, 1'b1);

    // single vectors, one table record each
    for (int t = 0; t < 4; t++) begin
      clear_nom();
      e = cyc + 1;
      step(1'b1, tbl[t].data, tbl[t].last, 1'b1, acc);
      chk("t1_acc", W'(acc), W'(1));
      idle(18, 1'b1);
      add_vec(e + 1, tbl[t].data);
      nom_dn[e + tbl[t].done_off] = 1'b1;
      set_busy(e + 1, e + tbl[t].busy_len);
      check_window($sformatf("t1_vec%0d", t), e, e + 18, 0, 0, 1'b1);
    end

    // three back-to-back vectors
    clear_nom();
    e = cyc + 1;
    step(1'b1, mk(20), 1'b0, 1'b1, acc);
    step(1'b1, mk(21), 1'b0, 1'b1, acc);
    step(1'b1, mk(22), 1'b1, 1'b1, acc);
    idle(20, 1'b1);
    add_vec(e + 1, mk(20));
    add_vec(e + 2, mk(21));
    add_vec(e + 3, mk(22));
    nom_dn[e + 16] = 1'b1;
    set_busy(e + 1, e + 16);
    check_window("t2_b2b", e, e + 20, 0, 0, 1'b1);

    // fill while frozen, 17th held, then release
    clear_nom();
    for (int k = 0; k < 16; k++) begin
      step(1'b1, mk(k), 1'b0, 1'b0, acc);
      chk($sformatf("t3_push%0d", k), W'(acc), W'(1));
    end
    chk("t3_full_ready", W'(in_ready_o), '0);
    repeat (3) begin
      step(1'b1, mk(16), 1'b1, 1'b0, acc);
      chk("t3_held", W'(acc), '0);
    end
    c = cyc;
    step(1'b1, mk(16), 1'b1, 1'b1, acc);
    chk("t3_held_raise", W'(acc), '0);
    step(1'b1, mk(16), 1'b1, 1'b1, acc);
    chk("t3_late_acc", W'(acc), W'(1));
    idle(36, 1'b1);
    for (int k = 0; k < 17; k++) add_vec(c + 1 + k, mk(k));
    nom_dn[c + 30] = 1'b1;
    check_window("t3_fill", c - 3, c + 36, 0, 0, 1'b0);

    // three-cycle freeze in the middle of the drain
    clear_nom();
    e = cyc + 1;
    step(1'b1, mk(30), 1'b0, 1'b1, acc);
    step(1'b1, mk(31), 1'b0, 1'b1, acc);
    step(1'b1, mk(32), 1'b1, 1'b1, acc);
    idle(2, 1'b1);
    idle(3, 1'b0);
    idle(22, 1'b1);
    add_vec(e + 1, mk(30));
    add_vec(e + 2, mk(31));
    add_vec(e + 3, mk(32));
    nom_dn[e + 16] = 1'b1;
    set_busy(e + 1, e + 16);
    check_window("t4_freeze", e, e + 26, e + 4, 3, 1'b1);

    // two-cycle input gap mid-tile
    clear_nom();
    e = cyc + 1;
    step(1'b1, mk(40), 1'b0, 1'b1, acc);
    step(1'b1, mk(41), 1'b0, 1'b1, acc);
    idle(2, 1'b1);
    step(1'b1, mk(42), 1'b0, 1'b1, acc);
    step(1'b1, mk(43), 1'b1, 1'b1, acc);
    idle(22, 1'b1);
    add_vec(e + 1, mk(40));
    add_vec(e + 2, mk(41));
    add_vec(e + 5, mk(42));
    add_vec(e + 6, mk(43));
    nom_dn[e + 19] = 1'b1;
    set_busy(e + 1, e + 19);
    check_window("t5_gap", e, e + 24, 0, 0, 1'b1);

    // reset while draining, next-tile vector queued
    step(1'b1, mk(50), 1'b1, 1'b1, acc);
    idle(2, 1'b1);
    step(1'b1, mk(51), 1'b0, 1'b1, acc);
    idle(3, 1'b1);
    chk("t6_pre_busy", W'(busy_o), W'(1));
    chk("t6_pre_lane5", W'(out_valid_o[5]), W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", W'(out_valid_o), '0);
    chk("t6_data", out_data_o, '0);
    chk("t6_done", W'(done_o), '0);
    chk("t6_busy", W'(busy_o), '0);
    chk("t6_ready", W'(in_ready_o), W'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_nom();
    e = cyc;
    idle(26, 1'b1);
    check_window("t6_post", e, e + 24, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
